// File: rtl/cail_sched_pkg.sv
// rtl/cail_sched_pkg.sv - shared types and constants for the calibration scheduler
package cail_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic COEF_SUB  = 1'b0;
    localparam logic COEF_MULT = 1'b1;

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/cail_sched_if.sv
// rtl/cail_sched_if.sv - scheduler to float calibration datapath bus
interface cail_sched_if;
    logic [15:0] dp_short_data;
    logic [31:0] dp_sub;
    logic [31:0] dp_mult;
    logic [31:0] dp_result;

    modport master (
        output dp_short_data,
        output dp_sub,
        output dp_mult,
        input  dp_result
    );

    modport slave (
        input  dp_short_data,
        input  dp_sub,
        input  dp_mult,
        output dp_result
    );
endinterface

// File: rtl/cail_sched_tag_pipe.sv
// rtl/cail_sched_tag_pipe.sv - LAT-deep {vld, ch} shift register shadowing the datapath latency
module cail_tag_pipe #(
    parameter int LAT = 16,
    parameter int CHW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    input  logic [CHW-1:0] in_ch,
    output logic           out_vld,
    output logic [CHW-1:0] out_ch
);

    logic [LAT-1:0]          vld_q, vld_d;
    logic [LAT-1:0][CHW-1:0] ch_q, ch_d;

    always_comb begin
        vld_d = {vld_q[LAT-2:0], in_vld};
        ch_d  = {ch_q[LAT-2:0], in_ch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ch_q  <= '0;
        end else begin
            vld_q <= vld_d;
            ch_q  <= ch_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_ch  = ch_q[LAT-1];

endmodule

// File: rtl/cail_sched.sv
// rtl/cail_sched.sv - frames ADC samples through the shared float calibration datapath
module cail_sched
    import cail_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CHW = 3,
    parameter int LAT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            smp_valid,
    input  logic [CHW-1:0]  smp_ch,
    input  logic [15:0]     smp_data,
    input  logic            frame_done,
    input  logic            coef_wr,
    input  logic            coef_sel,
    input  logic [CHW-1:0]  coef_ch,
    input  logic [31:0]     coef_data,
    output logic            coef_ready,
    cail_sched_if.master    dp,
    output logic            res_valid,
    output logic [CHW-1:0]  res_ch,
    output logic [31:0]     res_data,
    output logic            frame_out_done,
    output logic            busy,
    output logic            overrun
);

    localparam int CNTW = $clog2((NCH > LAT) ? NCH : LAT);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [15:0]     buf_q  [NCH];
    logic [15:0]     buf_d  [NCH];
    logic [31:0]     sub_q  [NCH];
    logic [31:0]     sub_d  [NCH];
    logic [31:0]     mult_q [NCH];
    logic [31:0]     mult_d [NCH];
    logic [15:0]     dp_short_q, dp_short_d;
    logic [31:0]     dp_sub_q, dp_sub_d;
    logic [31:0]     dp_mult_q, dp_mult_d;
    logic            busy_q, busy_d;
    logic            coef_ready_q, coef_ready_d;
    logic            overrun_q, overrun_d;
    logic            fod_q, fod_d;
    logic            tag_in_vld, tag_out_vld;
    logic [CHW-1:0]  tag_in_ch, tag_out_ch;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        sub_d      = sub_q;
        mult_d     = mult_q;
        dp_short_d = dp_short_q;
        dp_sub_d   = dp_sub_q;
        dp_mult_d  = dp_mult_q;
        overrun_d  = overrun_q;

        // Buffer and tables only move in IDLE so a frame sees one consistent snapshot.
        if (state_q == ST_IDLE && smp_valid) begin
            buf_d[smp_ch] = smp_data;
        end
        if (coef_ready_q && coef_wr) begin
            if (coef_sel == COEF_SUB) sub_d[coef_ch]  = coef_data;
            else                      mult_d[coef_ch] = coef_data;
        end
        if (state_q != ST_IDLE && frame_done) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_done) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == CNTW'(NCH - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNTW'(LAT - 1)) state_d = ST_DONE;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Preload so the datapath sees channel i during ISSUE cycle i, in step with its tag.
        if (state_d == ST_ISSUE) begin
            dp_short_d = buf_d[cnt_d[CHW-1:0]];
            dp_sub_d   = sub_d[cnt_d[CHW-1:0]];
            dp_mult_d  = mult_d[cnt_d[CHW-1:0]];
        end

        busy_d       = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        coef_ready_d = (state_d == ST_IDLE);
        fod_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dp_short_q   <= '0;
            dp_sub_q     <= FP_ZERO;
            dp_mult_q    <= FP_ZERO;
            busy_q       <= 1'b0;
            coef_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            fod_q        <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                buf_q[k]  <= '0;
                sub_q[k]  <= FP_ZERO;
                mult_q[k] <= FP_ZERO;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_short_q   <= dp_short_d;
            dp_sub_q     <= dp_sub_d;
            dp_mult_q    <= dp_mult_d;
            busy_q       <= busy_d;
            coef_ready_q <= coef_ready_d;
            overrun_q    <= overrun_d;
            fod_q        <= fod_d;
            buf_q        <= buf_d;
            sub_q        <= sub_d;
            mult_q       <= mult_d;
        end
    end

    assign tag_in_vld = (state_q == ST_ISSUE);
    assign tag_in_ch  = (state_q == ST_ISSUE) ? cnt_q[CHW-1:0] : '0;

    cail_tag_pipe #(
        .LAT (LAT),
        .CHW (CHW)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (tag_in_vld),
        .in_ch   (tag_in_ch),
        .out_vld (tag_out_vld),
        .out_ch  (tag_out_ch)
    );

    assign dp.dp_short_data = dp_short_q;
    assign dp.dp_sub        = dp_sub_q;
    assign dp.dp_mult       = dp_mult_q;

    assign res_valid      = tag_out_vld;
    assign res_ch         = tag_out_ch;
    assign res_data       = tag_out_vld ? dp.dp_result : FP_ZERO;
    assign frame_out_done = fod_q;
    assign busy           = busy_q;
    assign coef_ready     = coef_ready_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_cail_sched.sv
// tb/tb_cail_sched.sv - scoreboard bench for cail_sched with a LAT-cycle float datapath model
module tb_cail_sched;
    import cail_pkg::*;

    localparam int NCH = 8;
    localparam int CHW = 3;
    localparam int LAT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           smp_valid;
    logic [CHW-1:0] smp_ch;
    logic [15:0]    smp_data;
    logic           frame_done;
    logic           coef_wr;
    logic           coef_sel;
    logic [CHW-1:0] coef_ch;
    logic [31:0]    coef_data;
    logic           coef_ready;
    logic           res_valid;
    logic [CHW-1:0] res_ch;
    logic [31:0]    res_data;
    logic           frame_out_done;
    logic           busy;
    logic           overrun;

    cail_sched_if dpif ();

    cail_sched #(.NCH(NCH), .CHW(CHW), .LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .smp_valid      (smp_valid),
        .smp_ch         (smp_ch),
        .smp_data       (smp_data),
        .frame_done     (frame_done),
        .coef_wr        (coef_wr),
        .coef_sel       (coef_sel),
        .coef_ch        (coef_ch),
        .coef_data      (coef_data),
        .coef_ready     (coef_ready),
        .dp             (dpif),
        .res_valid      (res_valid),
        .res_ch         (res_ch),
        .res_data       (res_data),
        .frame_out_done (frame_out_done),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Float helpers via double bit repacking; all test values are exactly representable.
    function automatic real f32_to_real(input logic [31:0] b);
        logic [63:0] d;
        int e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]) - 127 + 1023;
        d = {b[31], e[10:0], b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= real_to_f32((real'($signed(dpif.dp_short_data)) - f32_to_real(dpif.dp_sub))
                                  * f32_to_real(dpif.dp_mult));
        for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
    assign dpif.dp_result = dp_pipe[LAT-1];

    int          exp_ch_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_first_q[$];
    logic [31:0] exp_v [NCH];
    int          run = 0;

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else begin
            if (frame_out_done) begin
                check_eq("fod_run_len", run, NCH);
                check_eq("fod_no_result", {31'd0, res_valid}, 32'd0);
            end
            if (res_valid) begin
                if (run == 0) begin
                    if (exp_first_q.size() == 0) check_eq("first_unexpected", cyc, 32'hFFFF_FFFF);
                    else check_eq("first_latency", cyc, exp_first_q.pop_front());
                end
                if (exp_ch_q.size() == 0) begin
                    check_eq("result_unexpected", {29'd0, res_ch}, 32'hFFFF_FFFF);
                end else begin
                    check_eq("res_ch", {29'd0, res_ch}, exp_ch_q.pop_front());
                    check_eq("res_data", res_data, exp_data_q.pop_front());
                end
                run++;
            end else begin
                run = 0;
            end
        end
    end

    task automatic write_coef(input logic sel, input int ch, input logic [31:0] data);
        coef_wr = 1'b1; coef_sel = sel; coef_ch = CHW'(ch); coef_data = data;
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    task automatic write_smp(input int ch, input logic [15:0] data);
        smp_valid = 1'b1; smp_ch = CHW'(ch); smp_data = data;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_done = 1'b1;
        exp_first_q.push_back(cyc + 1 + LAT);
        for (int i = 0; i < NCH; i++) begin
            exp_ch_q.push_back(i);
            exp_data_q.push_back(exp_v[i]);
        end
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (frame_out_done) seen = 1'b1;
        end
        if (!seen) check_eq("frame_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check_eq("sb_drained", exp_ch_q.size(), 32'd0);
    endtask

    task automatic load_default();
        for (int i = 0; i < NCH; i++) begin
            write_coef(COEF_SUB, i, FP_ZERO);
            write_coef(COEF_MULT, i, FP_ONE);
        end
        write_smp(2, 16'd555);
        for (int i = 0; i < NCH; i++) write_smp(i, 16'(100 + i));
        exp_v = '{32'h42C80000, 32'h42CA0000, 32'h42CC0000, 32'h42CE0000,
                  32'h42D00000, 32'h42D20000, 32'h42D40000, 32'h42D60000};
    endtask

    int nres;

    initial begin
        rst = 1'b1; smp_valid = 1'b0; smp_ch = '0; smp_data = '0; frame_done = 1'b0;
        coef_wr = 1'b0; coef_sel = 1'b0; coef_ch = '0; coef_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_coef_ready", {31'd0, coef_ready}, 32'd0);
        check_eq("rst_dp_short", {16'd0, dpif.dp_short_data}, 32'd0);
        check_eq("rst_fod", {31'd0, frame_out_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_coef_ready", {31'd0, coef_ready}, 32'd1);

        // Test 1: unity calibration
        load_default();
        start_frame();
        check_eq("issue_busy", {31'd0, busy}, 32'd1);
        wait_done();

        // Test 2: offset and gain on ch3 with a negative sample
        write_coef(COEF_SUB, 3, 32'h41200000);
        write_coef(COEF_MULT, 3, 32'h3F000000);
        write_smp(3, 16'hFFEC);
        exp_v[3] = 32'hC1700000;
        start_frame();
        wait_done();

        // Test 3: frame_done and sample write while busy
        start_frame();
        repeat (4) @(negedge clk);
        frame_done = 1'b1; smp_valid = 1'b1; smp_ch = '0; smp_data = 16'd999;
        @(negedge clk);
        frame_done = 1'b0; smp_valid = 1'b0;
        check_eq("overrun_set", {31'd0, overrun}, 32'd1);
        wait_done();

        // Test 4: coefficient write in DRAIN is dropped, in IDLE it lands
        start_frame();
        repeat (NCH + 2) @(negedge clk);
        check_eq("drain_coef_ready", {31'd0, coef_ready}, 32'd0);
        write_coef(COEF_SUB, 5, 32'h42C80000);
        wait_done();
        start_frame();
        wait_done();
        write_coef(COEF_SUB, 5, 32'h42C80000);
        exp_v[5] = 32'h40A00000;
        start_frame();
        wait_done();
        check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Test 5: reset mid-frame
        start_frame();
        repeat (8) @(negedge clk);
        rst = 1'b1;
        exp_ch_q.delete(); exp_data_q.delete(); exp_first_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_overrun", {31'd0, overrun}, 32'd0);
        check_eq("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        check_eq("midrst_dp_mult", dpif.dp_mult, 32'd0);
        check_eq("midrst_dp_sub", dpif.dp_sub, 32'd0);
        nres = 0;
        for (int t = 0; t < 2 * LAT; t++) begin
            @(negedge clk);
            if (res_valid) nres++;
        end
        check_eq("midrst_no_results", nres, 32'd0);
        load_default();
        start_frame();
        wait_done();

        // Test 6: back-to-back frames
        start_frame();
        wait_done();
        start_frame();
        wait_done();
        check_eq("b2b_no_overrun", {31'd0, overrun}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
